// File: rtl/div_pkg.sv
// Shared definitions for the iterative signed divider and its step datapath.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0]   w_shifted;
  logic [WIDTH+1:0] w_trial;

  // The shifted remainder needs WIDTH+1 bits; one extra bit carries the trial sign.
  assign w_shifted = {i_rem, i_quo[WIDTH-1]};
  assign w_trial   = {1'b0, w_shifted} - {2'b00, i_div};

  always_comb begin
    o_quo = {i_quo[WIDTH-2:0], 1'b0};
    o_rem = w_shifted[WIDTH-1:0];
    if (!w_trial[WIDTH+1]) begin
      o_quo[0] = 1'b1;
      o_rem    = w_trial[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/sequential_signed_divider.sv
// Iterative signed divider: magnitude restoring division followed by a sign fix-up.
// state | meaning
// IDLE  | waiting for start
// CALC  | one restoring step per clock, WIDTH steps
// FIX   | apply signs, load Q/R
// DONE  | result valid for one cycle, start accepted
module sequential_signed_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem, r_quo, r_mag_b;
  logic             r_sign_a, r_sign_b;

  logic             w_accept, w_b_zero, w_ovf;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_rem_nxt, w_quo_nxt;

  assign w_accept = start && (r_state == IDLE || r_state == DONE);
  assign w_b_zero = (b == '0);
  assign w_ovf    = (a == MOST_NEG) && (b == '1);
  // Negating the most negative value yields 2^(WIDTH-1) as an unsigned magnitude.
  assign w_abs_a  = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign w_abs_b  = b[WIDTH-1] ? (~b + 1'b1) : b;

  assign busy = (r_state == CALC) || (r_state == FIX);
  assign done = (r_state == DONE);

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_mag_b),
    .o_rem (w_rem_nxt),
    .o_quo (w_quo_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) w_state_nxt = (w_b_zero || w_ovf) ? DONE : CALC;
        else          w_state_nxt = IDLE;
      end
      CALC:    if (r_cnt == LAST_STEP) w_state_nxt = FIX;
      FIX:     w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_mag_b     <= '0;
      r_sign_a    <= 1'b0;
      r_sign_b    <= 1'b0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= w_abs_a;
      r_mag_b  <= w_abs_b;
      r_sign_a <= a[WIDTH-1];
      r_sign_b <= b[WIDTH-1];
      if (w_b_zero) begin
        Q           <= '1;
        R           <= a;
        div_by_zero <= 1'b1;
        overflow    <= 1'b0;
      end else if (w_ovf) begin
        Q           <= a;
        R           <= '0;
        div_by_zero <= 1'b0;
        overflow    <= 1'b1;
      end
    end else if (r_state == CALC) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt + 1'b1;
    end else if (r_state == FIX) begin
      Q           <= (r_sign_a ^ r_sign_b) ? (~r_quo + 1'b1) : r_quo;
      R           <= r_sign_a ? (~r_rem + 1'b1) : r_rem;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sequential_signed_divider.sv
// Directed self-checking bench for the sequential signed divider (WIDTH=32).
module tb_sequential_signed_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, div_by_zero, overflow;
  logic [31:0] Q, R;

  int checks = 0;
  int errors = 0;

  sequential_signed_divider #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .Q(Q), .R(R),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Drives one start pulse covering exactly one rising edge (E0).
  task automatic issue(input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom;
  endtask

  // Counts rising edges after E0 until done is seen; returns limit on timeout.
  task automatic wait_done(input int limit, output int edges);
    edges = limit;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); #1;
      if (done) begin edges = i; break; end
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({busy, done, div_by_zero, overflow} !== 4'b0 || Q !== 32'd0 || R !== 32'd0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b dz=%b ov=%b Q=%h R=%h expected all 0",
               busy, done, div_by_zero, overflow, Q, R);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_normal(input logic [31:0] va, input logic [31:0] vb,
                             input logic [31:0] eq, input logic [31:0] er);
    int n;
    issue(va, vb);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busy_after_capture got=%b expected 1", busy);
    end
    wait_done(60, n);
    checks++;
    if (n != 33) begin
      errors++; $display("FAIL latency a=%h b=%h got=%0d expected 33", va, vb, n);
    end
    checks++;
    if (Q !== eq || R !== er || div_by_zero !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL result a=%h b=%h Q=%h R=%h dz=%b ov=%b busy=%b expected Q=%h R=%h flags 0",
               va, vb, Q, R, div_by_zero, overflow, busy, eq, er);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || Q !== eq || R !== er) begin
      errors++; $display("FAIL done_one_cycle done=%b Q=%h R=%h expected done 0, Q=%h R=%h",
                         done, Q, R, eq, er);
    end
  endtask

  task automatic test_special(input logic [31:0] va, input logic [31:0] vb,
                              input logic [31:0] eq, input logic [31:0] er,
                              input logic edz, input logic eov);
    issue(va, vb);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL special_latency a=%h b=%h done=%b busy=%b expected done 1 busy 0",
                         va, vb, done, busy);
    end
    checks++;
    if (Q !== eq || R !== er || div_by_zero !== edz || overflow !== eov) begin
      errors++;
      $display("FAIL special_result a=%h b=%h Q=%h R=%h dz=%b ov=%b expected Q=%h R=%h dz=%b ov=%b",
               va, vb, Q, R, div_by_zero, overflow, eq, er, edz, eov);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || Q !== eq || div_by_zero !== edz || overflow !== eov) begin
      errors++; $display("FAIL special_hold done=%b Q=%h dz=%b ov=%b", done, Q, div_by_zero, overflow);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    issue(32'd100, 32'd7);
    repeat (10) @(posedge clk);
    @(negedge clk); a = 32'd5; b = 32'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(60, n);
    checks++;
    if (n != 22 || Q !== 32'd14 || R !== 32'd2) begin
      errors++; $display("FAIL ignore_mid_calc edges=%0d Q=%h R=%h expected edges 22 Q=0000000e R=00000002",
                         n, Q, R);
    end
    // Same cycle as done: start for the next operation.
    a = 32'd9; b = 32'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || Q !== 32'd14) begin
      errors++; $display("FAIL start_in_done done=%b busy=%b Q=%h expected done 0 busy 1 Q=0000000e",
                         done, busy, Q);
    end
    wait_done(60, n);
    checks++;
    if (n != 33 || Q !== 32'd4 || R !== 32'd1) begin
      errors++; $display("FAIL back_to_back edges=%0d Q=%h R=%h expected 33 Q=00000004 R=00000001",
                         n, Q, R);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    issue(32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, div_by_zero, overflow} !== 4'b0 || Q !== 32'd0 || R !== 32'd0) begin
      errors++; $display("FAIL reset_mid busy=%b done=%b dz=%b ov=%b Q=%h R=%h expected all 0",
                         busy, done, div_by_zero, overflow, Q, R);
    end
    @(negedge clk); reset = 1'b0;
    wait_done(40, n);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL reset_no_done done pulse seen after %0d edges expected none", n);
    end
    test_normal(32'd9, 32'd2, 32'd4, 32'd1);
  endtask

  initial begin
    test_reset;
    test_normal(32'd100, 32'd7, 32'd14, 32'd2);
    test_normal(-32'sd100, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE);
    test_normal(32'd100, -32'sd7, 32'hFFFFFFF2, 32'd2);
    test_normal(-32'sd100, -32'sd7, 32'd14, 32'hFFFFFFFE);
    test_normal(32'd3, 32'd7, 32'd0, 32'd3);
    test_special(32'd100, 32'd0, 32'hFFFFFFFF, 32'd100, 1'b1, 1'b0);
    test_special(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 1'b1);
    test_normal(32'h80000000, 32'd1, 32'h80000000, 32'd0);
    test_normal(32'h7FFFFFFF, 32'h80000000, 32'd0, 32'h7FFFFFFF);
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
